// File: rtl/rk4_freq_meter_if.sv
// Control/result bundle for the RK4 frequency meter.
// The meter sits on the slave side; the calibration controller sits on the master side.
interface rk4_freq_meter_if #(
    parameter int WINDOW_W = 16,
    parameter int COUNT_W  = 16
);
    logic                start;
    logic                abort;
    logic [WINDOW_W-1:0] window_len;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  count;
    logic                overflow;

    modport master (
        output start, abort, window_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, abort, window_len,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/rk4_freq_meter.sv
// Counts rising edges of an asynchronous clock over a programmable number of clk_in cycles.
// The result and saturation flag are published on a one-cycle done pulse.
module rk4_freq_meter #(
    parameter int WINDOW_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              meas_clk,
    rk4_freq_meter_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_MEAS   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                settle_q, settle_d;
    logic [WINDOW_W-1:0] win_q, win_d;
    logic [COUNT_W-1:0]  acc_q, acc_d;
    logic                sat_q, sat_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                s1_q, s2_q, s3_q;
    logic                edge_w;
    logic [COUNT_W:0]    inc_w;

    // Returns {sat, acc}; the accumulator sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] a,
                                                 input logic               sat);
        if (&a)
            sat_inc = {1'b1, a};
        else
            sat_inc = {sat, a + 1'b1};
    endfunction

    assign edge_w = s2_q & ~s3_q;
    assign inc_w  = edge_w ? sat_inc(acc_q, sat_q) : {sat_q, acc_q};

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    win_d    = bus.window_len;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                    settle_d = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Two cycles flush whatever the synchroniser held before the start.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (settle_q) begin
                    if (win_q == '0) begin
                        count_d = acc_q;
                        ovf_d   = sat_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MEAS;
                    end
                end else begin
                    settle_d = 1'b1;
                end
            end
            S_MEAS: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = inc_w[COUNT_W-1:0];
                    sat_d = inc_w[COUNT_W];
                    win_d = win_q - 1'b1;
                    if (win_q == {{(WINDOW_W-1){1'b0}}, 1'b1}) begin
                        count_d = inc_w[COUNT_W-1:0];
                        ovf_d   = inc_w[COUNT_W];
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= 1'b0;
            win_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            s1_q     <= meas_clk;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
        end
    end

    assign bus.busy     = (state_q == S_SETTLE) || (state_q == S_MEAS);
    assign bus.done     = (state_q == S_DONE);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule
